core_mc: RTL and testbench

- Parametrised successor of the single-output CORE: in-order, two-stage (ID, EX) integer execution core with a register file.
- Accepts 32-bit instructions over a valid/ready handshake.
- Detects RAW hazards with a scoreboard check against the EX stage.
- Routes each result to one of NUM_CH independent valid/ready output channels, selected by an instruction field.

---
 rtl/core_mc.sv | 195 +++++++++++++++++++
 tb/tb_core_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_mc.sv
// core_mc: two-stage (ID, EX) in-order integer core with a register file and
// NUM_CH independent valid/ready result channels.
//
// Instruction format (32 bits):
//   [31:30] op (00 ADD, 01 SUB, 10 AND, 11 XOR)
//   [29:25] rd   [24:20] rs1   [19:15] rs2   [14:13] channel   [12:0] ignored
//
// Ports:
//   i_CLK    clock, rising edge
//   i_RSTn   asynchronous active-low reset
//   i_instr  instruction, transferred on i_valid & o_ready
//   i_valid  instruction valid
//   o_ready  core can accept an instruction this cycle
//   i_ready  per-channel downstream ready
//   o_data   per-channel result, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   o_valid  per-channel result valid
//
// Optional build macro: CORE_MC_FWD_EN -- bypasses the EX result into ID when
// EX advances in the same cycle, removing the RAW-hazard bubble.

module core_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int NUM_REGS   = 32
) (
    input  logic                         i_CLK,
    input  logic                         i_RSTn,
    input  logic [31:0]                  i_instr,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_CH-1:0]            i_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic [NUM_CH-1:0]            o_valid
);
    // Two channels decode bit 13 only; three or four decode both bits.
    localparam logic [1:0] CH_MASK = (NUM_CH == 2) ? 2'b01 : 2'b11;

    genvar gi;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  id_valid;
    logic [1:0]            id_op;
    logic [4:0]            id_rd;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic [1:0]            id_ch;

    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_result;
    logic [4:0]            ex_rd;
    logic [1:0]            ex_ch;

    logic                  out_valid [NUM_CH];
    logic [DATA_WIDTH-1:0] out_data  [NUM_CH];

    logic                  in_fire;
    logic                  hazard;
    logic                  id_adv;
    logic                  ex_adv;
    logic                  slot_free;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_a;
    logic [DATA_WIDTH-1:0] rf_b;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu;
    logic [1:0]            ch_sel;
    logic [12:0]           unused_bits;

    assign unused_bits = i_instr[12:0];

    // Combinational register read; indices >= NUM_REGS match nothing and read 0.
    // regs[0] is never written, so R0 reads 0 through the same path.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (id_rs1 == 5'(i)) rf_a = regs[i];
            if (id_rs2 == 5'(i)) rf_b = regs[i];
        end
    end

    always_comb begin
        slot_free = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ex_ch == 2'(c)) slot_free = !out_valid[c] || i_ready[c];
        end
    end

    assign hazard  = ex_valid && (ex_rd != 5'd0) && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
    assign ex_adv  = ex_valid && slot_free;
    assign rf_we   = ex_adv && (ex_rd != 5'd0);
    assign o_ready = !id_valid || id_adv;
    assign in_fire = i_valid && o_ready;

`ifdef CORE_MC_FWD_EN
    // Only architecturally real registers are bypassed; an out-of-range rd
    // would read back as 0, so the register-file value is kept for it.
    logic ex_rd_real;
    assign ex_rd_real = (ex_rd != 5'd0) && ({1'b0, ex_rd} < 6'(NUM_REGS));
    assign op_a   = (ex_valid && ex_rd_real && (id_rs1 == ex_rd)) ? ex_result : rf_a;
    assign op_b   = (ex_valid && ex_rd_real && (id_rs2 == ex_rd)) ? ex_result : rf_b;
    // A hazard no longer blocks ID once EX is leaving this cycle.
    assign id_adv = id_valid && (!ex_valid || ex_adv);
`else
    assign op_a   = rf_a;
    assign op_b   = rf_b;
    assign id_adv = id_valid && !hazard && (!ex_valid || ex_adv);
`endif

    always_comb begin
        case (id_op)
            2'b00:   alu = op_a + op_b;
            2'b01:   alu = op_a - op_b;
            2'b10:   alu = op_a & op_b;
            default: alu = op_a ^ op_b;
        endcase
    end

    // Channel values that exceed NUM_CH fall back to channel 0.
    always_comb begin
        ch_sel = id_ch & CH_MASK;
        if (32'(ch_sel) >= NUM_CH) ch_sel = 2'd0;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            id_valid  <= 1'b0;
            id_op     <= '0;
            id_rd     <= '0;
            id_rs1    <= '0;
            id_rs2    <= '0;
            id_ch     <= '0;
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_rd     <= '0;
            ex_ch     <= '0;
        end else begin
            if (in_fire) begin
                id_valid <= 1'b1;
                id_op    <= i_instr[31:30];
                id_rd    <= i_instr[29:25];
                id_rs1   <= i_instr[24:20];
                id_rs2   <= i_instr[19:15];
                id_ch    <= i_instr[14:13];
            end else if (id_adv) begin
                id_valid <= 1'b0;
            end

            if (id_adv) begin
                ex_valid  <= 1'b1;
                ex_result <= alu;
                ex_rd     <= id_rd;
                ex_ch     <= ch_sel;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Register i resets to 5*i (truncated to DATA_WIDTH).
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_rf
        always_ff @(posedge i_CLK or negedge i_RSTn) begin
            if (!i_RSTn) begin
                regs[gi] <= DATA_WIDTH'(5 * gi);
            end else if (rf_we && (ex_rd == 5'(gi))) begin
                regs[gi] <= ex_result;
            end
        end
    end

    // Single-entry output register per channel; reload wins over drain so a
    // handshake and a new result in the same cycle stay back-to-back.
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic load;
        assign load = ex_adv && (ex_ch == 2'(gi));

        always_ff @(posedge i_CLK or negedge i_RSTn) begin
            if (!i_RSTn) begin
                out_valid[gi] <= 1'b0;
                out_data[gi]  <= '0;
            end else if (load) begin
                out_valid[gi] <= 1'b1;
                out_data[gi]  <= ex_result;
            end else if (i_ready[gi]) begin
                out_valid[gi] <= 1'b0;
            end
        end

        assign o_valid[gi]                              = out_valid[gi];
        assign o_data[gi*DATA_WIDTH +: DATA_WIDTH]      = out_data[gi];
    end

endmodule

// File: tb/tb_core_mc.sv
// Scoreboard testbench for core_mc (DATA_WIDTH=8, NUM_CH=2, NUM_REGS=32).
// The driver pushes each hand-computed result onto the queue of its channel
// when the instruction is accepted; an independent monitor pops and compares
// whenever a channel completes a valid/ready handshake.

module tb_core_mc;
    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid;
    logic        core_ready;
    logic [1:0]  ch_ready;
    logic [15:0] ch_data;
    logic [1:0]  ch_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_pop [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

`ifdef CORE_MC_FWD_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] XOR = 2'b11;

    core_mc dut (
        .i_CLK   (clk),
        .i_RSTn  (rst_n),
        .i_instr (instr),
        .i_valid (in_valid),
        .o_ready (core_ready),
        .i_ready (ch_ready),
        .o_data  (ch_data),
        .o_valid (ch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitor: a handshake seen here completes at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (ch_valid[c] && ch_ready[c]) begin
                    logic [7:0] got;
                    logic [7:0] exp;
                    int         sz;
                    got = ch_data[c*8 +: 8];
                    sz  = (c == 0) ? sb0.size() : sb1.size();
                    checks++;
                    if (sz == 0) begin
                        errors++;
                        $display("FAIL ch%0d_unexpected got=%0d expected=none", c, got);
                    end else begin
                        exp = (c == 0) ? sb0.pop_front() : sb1.pop_front();
                        $display("cyc=%0d ch%0d data=%0d expected=%0d", cyc, c, got, exp);
                        if (got != exp) begin
                            errors++;
                            $display("FAIL ch%0d_data got=%0d expected=%0d", c, got, exp);
                        end
                    end
                    last_pop[c] = cyc;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [1:0] chf, input int expch,
                        input logic [7:0] exp);
        int n;
        n = 0;
        instr    = {op, rd, rs1, rs2, chf, 13'h0};
        in_valid = 1'b1;
        @(negedge clk);
        while (!core_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!core_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=stalled expected=accept rd=%0d", rd);
            in_valid = 1'b0;
        end else begin
            if (expch == 0) sb0.push_back(exp);
            else            sb1.push_back(exp);
            accept_cyc = cyc + 1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb0.size() + sb1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        ch_ready = 2'b11;
        last_pop[0] = 0;
        last_pop[1] = 0;
        #1;
        chk("reset_valid", ch_valid, 0);
        chk("reset_data", ch_data, 0);
        chk("reset_ready", core_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD, latency two edges after accept.
        send(ADD, 5'd3, 5'd1, 5'd2, 2'd0, 0, 8'd15);
        a0 = accept_cyc;
        drain("t1_drain");
        chk("t1_latency", last_pop[0] - a0, 2);

        // Dependent pair: one bubble without bypass.
        send(ADD, 5'd3, 5'd1, 5'd2, 2'd0, 0, 8'd15);
        send(SUB, 5'd4, 5'd3, 5'd2, 2'd1, 1, 8'd5);
        drain("t2_drain");
        chk("t2_gap", last_pop[1] - last_pop[0], GAP);

        // Hazards whose stale operand would give a different value.
        send(ADD, 5'd16, 5'd1, 5'd1, 2'd0, 0, 8'd10);
        send(SUB, 5'd17, 5'd16, 5'd2, 2'd1, 1, 8'd0);
        send(XOR, 5'd18, 5'd0, 5'd17, 2'd0, 0, 8'd0);
        drain("t2b_drain");

        // Blocked channel 0: head-of-line stall back to o_ready.
        ch_ready[0] = 1'b0;
        fork
            begin
                send(XOR, 5'd5, 5'd1, 5'd2, 2'd0, 0, 8'd15);
                send(ADD, 5'd9, 5'd1, 5'd1, 2'd0, 0, 8'd10);
                send(AND, 5'd10, 5'd2, 5'd3, 2'd1, 1, 8'd10);
                send(XOR, 5'd11, 5'd4, 5'd1, 2'd0, 0, 8'd0);
            end
            begin
                repeat (10) @(negedge clk);
                chk("stall_ready", core_ready, 0);
                chk("stall_valid", ch_valid, 1);
                chk("stall_hold", ch_data[7:0], 15);
                repeat (3) @(negedge clk);
                chk("stall_hold2", ch_data[7:0], 15);
                @(posedge clk);
                #1;
                ch_ready[0] = 1'b1;
            end
        join
        drain("t3_drain");

        // Wrap-around, channel remapping.
        send(ADD, 5'd6, 5'd31, 5'd31, 2'd3, 1, 8'd54);
        send(SUB, 5'd7, 5'd1, 5'd2, 2'd0, 0, 8'd251);
        send(AND, 5'd12, 5'd9, 5'd5, 2'd2, 0, 8'd10);
        drain("t4_drain");

        // R0 write ignored, no hazard stall on R0.
        send(ADD, 5'd0, 5'd1, 5'd2, 2'd0, 0, 8'd15);
        send(ADD, 5'd8, 5'd0, 5'd1, 2'd1, 1, 8'd5);
        drain("t5_drain");
        chk("t5_gap", last_pop[1] - last_pop[0], 1);

        // Asynchronous reset while data is held in the output and EX.
        ch_ready = 2'b00;
        send(ADD, 5'd3, 5'd9, 5'd9, 2'd0, 0, 8'd20);
        send(ADD, 5'd13, 5'd1, 5'd1, 2'd0, 0, 8'd10);
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", ch_valid, 1);
        chk("pre_rst_data", ch_data[7:0], 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ch_valid, 0);
        chk("async_rst_data", ch_data, 0);
        chk("async_rst_ready", core_ready, 1);
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ch_ready = 2'b11;
        send(ADD, 5'd14, 5'd3, 5'd1, 2'd1, 1, 8'd20);
        send(ADD, 5'd3, 5'd1, 5'd2, 2'd0, 0, 8'd15);
        send(ADD, 5'd15, 5'd9, 5'd0, 2'd0, 0, 8'd45);
        drain("t6_drain");

        repeat (3) @(negedge clk);
        chk("final_idle", ch_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
